accum_64: RTL and testbench
===========================

ACCUM_64 -- requirements
Module: accum_64

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream operand valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts an operand this cycle.
REQ-005 SHALL have port in_data, input, 64, operand to add to the accumulator.
REQ-006 SHALL have port in_cin, input, 1, carry-in for this operand.
REQ-007 SHALL have port in_clear, input, 1, qualified by in_valid; replaces the accumulator instead of adding to it.
REQ-008 SHALL have port add_in1, output, 64, registered operand A to the external adder_64 in1.
REQ-009 SHALL have port add_in2, output, 64, registered operand B to the external adder_64 in2.
REQ-010 SHALL have port add_cin, output, 1, registered carry to the external adder_64 cin.
REQ-011 SHALL have port add_sum, input, 64, adder_64 sum; combinational path from the add_* registers.
REQ-012 SHALL have port add_cout, input, 1, adder_64 cout.
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port acc, output, 64, accumulator value.
REQ-016 SHALL have port cout_sticky, output, 1, set when any add since the last clear produced a carry-out.
REQ-017 SHALL have port carry_cnt, output, 8, count of carry-outs since the last clear, saturating.

Function
REQ-018 SHALL implement FSM states IDLE, ADD and HOLD; in_ready = 1 only in IDLE; out_valid = 1 only in HOLD.
REQ-019 SHALL accept an operand on a rising edge where the state is IDLE and in_valid = 1, then go to ADD.
REQ-020 On accept: add_in1 <= (in_clear ? 0 : acc); add_in2 <= in_data; add_cin <= in_cin; clr_pend <= in_clear.
REQ-021 In ADD, on the next edge: acc <= add_sum; go to HOLD.
REQ-022 In ADD, when clr_pend = 1: cout_sticky <= add_cout; carry_cnt <= {7'b0, add_cout}.
REQ-023 In ADD, when clr_pend = 0: cout_sticky <= cout_sticky | add_cout; carry_cnt increments by add_cout and saturates at 255, with no wrap to 0.
REQ-024 In HOLD, stay in HOLD while out_ready = 0, with acc, cout_sticky and carry_cnt stable; on an edge with out_ready = 1, go to IDLE.
REQ-025 Latency: operand accepted at edge T gives out_valid high after edge T+1; minimum spacing between accepts is 3 cycles when out_ready is held at 1.
REQ-026 Arithmetic is modulo 2^64; the carry beyond bit 63 is visible only through cout_sticky and carry_cnt.
REQ-027 Inputs in any state other than IDLE SHALL be ignored, including in_valid, in_clear and in_data changes.
REQ-028 add_* outputs SHALL hold their values from accept until the next accept.

Reset
REQ-029 While rst = 1, asynchronously: state = IDLE; acc, add_in1, add_in2 = 0; add_cin, clr_pend, cout_sticky = 0; carry_cnt = 0.
REQ-030 Hence during reset in_ready = 1 and out_valid = 0.
REQ-031 Reset asserted in ADD or HOLD SHALL discard the in-flight result; the first edge after release behaves as IDLE.

Verification
REQ-032 Reset, then clear-load 64'h0000_0000_0000_0005 with cin = 0, then add 64'h3 with cin = 1 -> acc = 9; sticky = 0; cnt = 0; out_valid high after edge T+1 on each.
REQ-033 Clear-load 64'hFFFF_FFFF_FFFF_FFFF, then add 1 with cin = 0 -> acc = 0; sticky = 1; cnt = 1; then add 64'h5 -> acc = 5; sticky = 1; cnt = 1.
REQ-034 Hold out_ready = 0 for 10 cycles in HOLD while toggling in_valid and in_data -> acc unchanged and in_ready = 0; after out_ready = 1, IDLE on the next edge.
REQ-035 Repeatedly add 64'hFFFF_FFFF_FFFF_FFFF with cin = 1 (each add carries) 300 times -> carry_cnt saturates at 255; a following clear-load of 0 -> cnt = 0 and sticky = 0.
REQ-036 Assert rst asynchronously mid-ADD -> all outputs zero immediately; in_ready = 1; no out_valid for the aborted operand.
REQ-037 Random stream with a reference model, random in_clear and backpressure, 10k operands -> acc, sticky and cnt match the model on every out_valid & out_ready handshake.

Source files
------------

// File: rtl/accum_64.sv
// accum_64: a 64-bit accumulator built around an external adder_64.
//
// Each accepted operand is staged into registered adder operands
// (add_in1/add_in2/add_cin). The next edge captures the external sum into
// acc. The result is then held until downstream takes it. A "clear" operand
// replaces the accumulator rather than adding to it: the adder's A input is
// forced to zero, and the carry statistics restart from that add's carry-out.
//
// Ports
//   clk, rst            : single clock; asynchronous active-high reset
//   in_valid/in_ready   : operand handshake; ready only in IDLE
//   in_data, in_cin     : operand and carry-in
//   in_clear            : operand replaces acc (qualified by in_valid)
//   add_in1/2, add_cin  : registered operands to the external adder_64
//   add_sum, add_cout   : combinational result of the external adder_64
//   out_valid/out_ready : result handshake; valid only in HOLD
//   acc                 : accumulator value
//   cout_sticky         : any carry-out since the last clear
//   carry_cnt           : carry-outs since the last clear, saturating at 255
module accum_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_cin,
  input  logic        in_clear,
  output logic [63:0] add_in1,
  output logic [63:0] add_in2,
  output logic        add_cin,
  input  logic [63:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] acc,
  output logic        cout_sticky,
  output logic [7:0]  carry_cnt
);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] add_in1_q, add_in1_d;
  logic [63:0] add_in2_q, add_in2_d;
  logic        add_cin_q, add_cin_d;
  logic        clr_pend_q, clr_pend_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      add_in1_q  <= '0;
      add_in2_q  <= '0;
      add_cin_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      add_in1_q  <= add_in1_d;
      add_in2_q  <= add_in2_d;
      add_cin_q  <= add_cin_d;
      clr_pend_q <= clr_pend_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    add_in1_d  = add_in1_q;
    add_in2_d  = add_in2_q;
    add_cin_d  = add_cin_q;
    clr_pend_d = clr_pend_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // A clear feeds zero as operand A, so the same adder path loads
          // in_data + in_cin and still reports a genuine carry-out.
          add_in1_d  = in_clear ? 64'd0 : acc_q;
          add_in2_d  = in_data;
          add_cin_d  = in_cin;
          clr_pend_d = in_clear;
          state_d    = ADD;
        end
      end
      ADD: begin
        acc_d = add_sum;
        if (clr_pend_q) begin
          sticky_d = add_cout;
          cnt_d    = {7'b0, add_cout};
        end else begin
          sticky_d = sticky_q | add_cout;
          if (add_cout && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign add_in1     = add_in1_q;
  assign add_in2     = add_in2_q;
  assign add_cin     = add_cin_q;
  assign acc         = acc_q;
  assign cout_sticky = sticky_q;
  assign carry_cnt   = cnt_q;

endmodule

// File: tb/tb_accum_64.sv
module tb_accum_64;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_cin;
  logic        in_clear;
  logic [63:0] add_in1;
  logic [63:0] add_in2;
  logic        add_cin;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] acc;
  logic        cout_sticky;
  logic [7:0]  carry_cnt;

  int n_run;
  int n_fail;

  accum_64 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_cin     (in_cin),
    .in_clear   (in_clear),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .cout_sticky(cout_sticky),
    .carry_cnt  (carry_cnt)
  );

  // External adder_64 stand-in.
  logic [64:0] adder_full;
  assign adder_full = {1'b0, add_in1} + {1'b0, add_in2} + {64'd0, add_cin};
  assign add_sum    = adder_full[63:0];
  assign add_cout   = adder_full[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand for exactly one edge (the DUT must be in IDLE).
  task automatic accept(input logic [63:0] d, input logic c, input logic clr);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    in_clear = clr;
    step();
    in_valid = 1'b0;
    in_clear = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_run++;
    if (acc !== 64'd0 || add_in1 !== 64'd0 || add_in2 !== 64'd0 || add_cin !== 1'b0 ||
        cout_sticky !== 1'b0 || carry_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_vals: acc=%h in1=%h in2=%h cin=%b st=%b cnt=%0d want all 0",
               acc, add_in1, add_in2, add_cin, cout_sticky, carry_cnt);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    accept(64'h5, 1'b0, 1'b1);
    n_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || add_in1 !== 64'd0 || add_in2 !== 64'h5) begin
      n_fail++;
      $display("FAIL basic_add_state: rdy=%b ov=%b in1=%h in2=%h want 0/0/0/5",
               in_ready, out_valid, add_in1, add_in2);
    end
    step();
    n_run++;
    if (out_valid !== 1'b1 || acc !== 64'd5 || cout_sticky !== 1'b0 || carry_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_load: ov=%b acc=%h st=%b cnt=%0d want 1/5/0/0",
               out_valid, acc, cout_sticky, carry_cnt);
    end
    release_hold();
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: rdy=%b ov=%b want 1/0", in_ready, out_valid);
    end
    accept(64'h3, 1'b1, 1'b0);
    n_run++;
    if (out_valid !== 1'b0 || add_in1 !== 64'd5 || add_cin !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_add_ops: ov=%b in1=%h cin=%b want 0/5/1", out_valid, add_in1, add_cin);
    end
    step();
    n_run++;
    if (out_valid !== 1'b1 || acc !== 64'd9 || cout_sticky !== 1'b0 || carry_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_sum: ov=%b acc=%h st=%b cnt=%0d want 1/9/0/0",
               out_valid, acc, cout_sticky, carry_cnt);
    end
    release_hold();
  endtask

  task automatic test_carry();
    accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    step();
    n_run++;
    if (acc !== 64'hFFFF_FFFF_FFFF_FFFF || cout_sticky !== 1'b0 || carry_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL carry_load: acc=%h st=%b cnt=%0d want ffffffffffffffff/0/0",
               acc, cout_sticky, carry_cnt);
    end
    release_hold();
    accept(64'h1, 1'b0, 1'b0);
    step();
    n_run++;
    if (acc !== 64'd0 || cout_sticky !== 1'b1 || carry_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL carry_wrap: acc=%h st=%b cnt=%0d want 0/1/1", acc, cout_sticky, carry_cnt);
    end
    release_hold();
    accept(64'h5, 1'b0, 1'b0);
    step();
    n_run++;
    if (acc !== 64'd5 || cout_sticky !== 1'b1 || carry_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL carry_sticky: acc=%h st=%b cnt=%0d want 5/1/1", acc, cout_sticky, carry_cnt);
    end
    release_hold();
  endtask

  task automatic test_hold();
    accept(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      in_clear = 1'($urandom);
      in_cin   = 1'($urandom);
      in_data  = {$urandom, $urandom};
      step();
      n_run++;
      if (acc !== 64'hDEAD_BEEF_0000_0001 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
          add_in2 !== 64'hDEAD_BEEF_0000_0001 || add_in1 !== 64'd0) begin
        n_fail++;
        $display("FAIL hold_c%0d: acc=%h rdy=%b ov=%b in1=%h in2=%h want deadbeef00000001/0/1/0/deadbeef00000001",
                 i, acc, in_ready, out_valid, add_in1, add_in2);
      end
    end
    // in_valid is high on the releasing edge; it must not be taken from HOLD.
    in_valid = 1'b1;
    release_hold();
    in_valid = 1'b0;
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL hold_release: rdy=%b ov=%b acc=%h want 1/0/deadbeef00000001",
               in_ready, out_valid, acc);
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 300; i++) begin
      accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, (i == 1));
      step();
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
        n_run++;
        if (carry_cnt !== ((i > 255) ? 8'd255 : 8'(i)) || cout_sticky !== 1'b1 || acc !== 64'd0) begin
          n_fail++;
          $display("FAIL sat_add%0d: cnt=%0d st=%b acc=%h want %0d/1/0",
                   i, carry_cnt, cout_sticky, acc, (i > 255) ? 255 : i);
        end
      end
      release_hold();
    end
    accept(64'd0, 1'b0, 1'b1);
    step();
    n_run++;
    if (carry_cnt !== 8'd0 || cout_sticky !== 1'b0 || acc !== 64'd0) begin
      n_fail++;
      $display("FAIL sat_clear: cnt=%0d st=%b acc=%h want 0/0/0", carry_cnt, cout_sticky, acc);
    end
    release_hold();
  endtask

  task automatic test_async_reset();
    accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    step();
    release_hold();
    accept(64'h2, 1'b0, 1'b0);
    step();
    release_hold();
    n_run++;
    if (acc !== 64'd1 || cout_sticky !== 1'b1 || carry_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL arst_pre: acc=%h st=%b cnt=%0d want 1/1/1", acc, cout_sticky, carry_cnt);
    end
    accept(64'h1234, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_run++;
    if (acc !== 64'd0 || add_in1 !== 64'd0 || add_in2 !== 64'd0 || add_cin !== 1'b0 ||
        cout_sticky !== 1'b0 || carry_cnt !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_mid_add: acc=%h in1=%h in2=%h cin=%b st=%b cnt=%0d rdy=%b ov=%b want zeros rdy=1",
               acc, add_in1, add_in2, add_cin, cout_sticky, carry_cnt, in_ready, out_valid);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc !== 64'd0) begin
        n_fail++;
        $display("FAIL arst_after%0d: ov=%b rdy=%b acc=%h want 0/1/0", i, out_valid, in_ready, acc);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] m_acc;
    logic        m_sticky;
    int          m_cnt;
    logic [64:0] s;
    logic [63:0] d;
    logic        c;
    logic        clr;
    bit          done;
    int          guard;
    m_acc = '0;
    m_sticky = 1'b0;
    m_cnt = 0;
    for (int op = 0; op < 10000; op++) begin
      if ($urandom_range(0, 3) == 0) step();
      case ($urandom_range(0, 7))
        0:       d = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       d = 64'd0;
        2:       d = {32'hFFFF_FFFF, $urandom};
        default: d = {$urandom, $urandom};
      endcase
      c   = 1'($urandom);
      clr = (op == 0) || ($urandom_range(0, 199) == 0);
      n_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_ready op%0d: rdy=%b ov=%b want 1/0", op, in_ready, out_valid);
      end
      accept(d, c, clr);
      s = (clr ? 65'd0 : {1'b0, m_acc}) + {1'b0, d} + {64'd0, c};
      m_acc = s[63:0];
      if (clr) begin
        m_sticky = s[64];
        m_cnt    = int'(s[64]);
      end else begin
        m_sticky = m_sticky | s[64];
        if (s[64] && m_cnt < 255) m_cnt++;
      end
      // Noise while the add is in flight.
      in_valid = 1'($urandom);
      in_clear = 1'($urandom);
      in_data  = {$urandom, $urandom};
      step();
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 50) begin
        out_ready = ($urandom_range(0, 9) < 7);
        in_valid  = 1'($urandom);
        in_clear  = 1'($urandom);
        in_data   = {$urandom, $urandom};
        if (out_ready) begin
          n_run++;
          if (out_valid !== 1'b1 || acc !== m_acc || cout_sticky !== m_sticky ||
              carry_cnt !== 8'(m_cnt)) begin
            n_fail++;
            $display("FAIL rnd_op%0d: ov=%b acc=%h st=%b cnt=%0d want 1/%h/%b/%0d",
                     op, out_valid, acc, cout_sticky, carry_cnt, m_acc, m_sticky, m_cnt);
          end
          done = 1'b1;
        end
        step();
        guard++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_clear  = 1'b0;
      if (!done) begin
        n_run++;
        n_fail++;
        $display("FAIL rnd_timeout op%0d: no handshake within 50 cycles", op);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cin    = 1'b0;
    in_clear  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
